// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encodings and width defaults for the modexp requester
package rsa_pkg;

  localparam int WIDTH_DEFAULT     = 32;
  localparam int MOD_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RED_BASE,
    TEST_BIT,
    MUL,
    SQR,
    SHIFT,
    FINISH
  } modexp_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_REL
  } hs_state_t;

endpackage

// File: rtl/mod_handshake_master.sv
// rtl/mod_handshake_master.sv - four-phase initiator towards the modular reduction unit
module mod_handshake_master
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] modulus,
  input  logic             modular_done,
  input  logic [WIDTH-1:0] mod_result,
  output logic             modular_ready,
  output logic [WIDTH-1:0] numerator,
  output logic [WIDTH-1:0] denominator,
  output logic             complete,
  output logic [WIDTH-1:0] data
);

  hs_state_t state, state_next;
  logic      pending;

  // Request is only visible while the handshake sits in HS_REQ; operands were registered earlier.
  assign modular_ready = (state == HS_REQ);

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state <= HS_IDLE;
    else       state <= state_next;
  end

  // Next state: raise only once the responder has released done, then wait for done to fall again.
  always_comb begin
    state_next = state;
    case (state)
      HS_IDLE: if (pending && !modular_done) state_next = HS_REQ;
      HS_REQ:  if (modular_done)             state_next = HS_REL;
      HS_REL:  if (!modular_done)            state_next = HS_IDLE;
      default:                               state_next = HS_IDLE;
    endcase
  end

  // Operand latch, pending-request flag, result capture and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      numerator   <= '0;
      denominator <= '0;
      data        <= '0;
      pending     <= 1'b0;
      complete    <= 1'b0;
    end else begin
      complete <= (state == HS_REQ) && modular_done;
      if ((state == HS_REQ) && modular_done) data <= mod_result;
      if ((state == HS_IDLE) && pending && !modular_done) pending <= 1'b0;
      if (issue) begin
        numerator   <= operand;
        denominator <= modulus;
        pending     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/modexp_requester.sv
// rtl/modexp_requester.sv - right-to-left square-and-multiply controller using an external reducer
module modexp_requester
  import rsa_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MOD_WIDTH = MOD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             modular_ready,
  output logic [WIDTH-1:0] numerator,
  output logic [WIDTH-1:0] denominator,
  input  logic             modular_done,
  input  logic [WIDTH-1:0] mod_result
);

  modexp_state_t    state, state_next;
  logic [WIDTH-1:0] b, e, n, r;
  logic [WIDTH-1:0] operand, data;
  logic             issue, complete;
  logic             bad_mod;

  // Zero modulus or one wider than MOD_WIDTH would let residue products overflow WIDTH.
  assign bad_mod = (n == '0) || ((n >> MOD_WIDTH) != '0);
  assign done    = (state == FINISH);

  // Main state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; a reduction is issued on the transition into RED_BASE, MUL or SQR.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    operand    = b;
    case (state)
      IDLE:     if (start) state_next = CHECK;
      CHECK: begin
        if (bad_mod || (n == WIDTH'(1))) begin
          state_next = FINISH;
        end else begin
          state_next = RED_BASE;
          issue      = 1'b1;
          operand    = b;
        end
      end
      RED_BASE: if (complete) state_next = TEST_BIT;
      TEST_BIT: begin
        if (e == '0) begin
          state_next = FINISH;
        end else if (e[0]) begin
          state_next = MUL;
          issue      = 1'b1;
          operand    = r * b;
        end else begin
          state_next = SHIFT;
        end
      end
      MUL:      if (complete) state_next = SHIFT;
      SHIFT: begin
        if ((e >> 1) != '0) begin
          state_next = SQR;
          issue      = 1'b1;
          operand    = b * b;
        end else begin
          state_next = TEST_BIT;
        end
      end
      SQR:      if (complete) state_next = TEST_BIT;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Operand registers, accumulator, and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      b      <= '0;
      e      <= '0;
      n      <= '0;
      r      <= '0;
      result <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b    <= base;
            e    <= exponent;
            n    <= modulus;
            r    <= WIDTH'(1);
            busy <= 1'b1;
            err  <= 1'b0;
          end
        end
        CHECK: begin
          if (bad_mod) begin
            result <= '0;
            err    <= 1'b1;
            busy   <= 1'b0;
          end else if (n == WIDTH'(1)) begin
            result <= '0;
            busy   <= 1'b0;
          end
        end
        RED_BASE: if (complete) b <= data;
        TEST_BIT: begin
          if (e == '0) begin
            result <= r;
            busy   <= 1'b0;
          end
        end
        MUL:      if (complete) r <= data;
        SHIFT:    e <= e >> 1;
        SQR:      if (complete) b <= data;
        default:  ;
      endcase
    end
  end

  mod_handshake_master #(.WIDTH(WIDTH)) u_hs (
    .clk           (clk),
    .reset         (reset),
    .issue         (issue),
    .operand       (operand),
    .modulus       (n),
    .modular_done  (modular_done),
    .mod_result    (mod_result),
    .modular_ready (modular_ready),
    .numerator     (numerator),
    .denominator   (denominator),
    .complete      (complete),
    .data          (data)
  );

endmodule

// File: tb/tb_modexp_requester.sv
// tb/tb_modexp_requester.sv - directed and random checks of modexp_requester against a reference model
module tb_modexp_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base, exponent, modulus;
  logic        busy, done, err;
  logic [31:0] result;
  logic        modular_ready;
  logic [31:0] numerator, denominator;
  logic        modular_done = 1'b0;
  logic [31:0] mod_result = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder configuration and observations.
  int          lat_min = 3, lat_max = 3, hold_extra = 0;
  int          hs_count = 0, proto_err = 0, stab_err = 0;
  int          rs = 0, cnt = 0;
  logic [31:0] snap_n = '0, snap_d = '0;
  logic        prev_ready = 1'b0;

  modexp_requester dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base          (base),
    .exponent      (exponent),
    .modulus       (modulus),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .result        (result),
    .modular_ready (modular_ready),
    .numerator     (numerator),
    .denominator   (denominator),
    .modular_done  (modular_done),
    .mod_result    (mod_result)
  );

  always #5 clk = ~clk;

  // Behavioural reduction unit: random latency, optional extra done-hold after ready drops.
  always @(negedge clk) begin
    if (modular_ready && !prev_ready && modular_done) proto_err++;
    prev_ready = modular_ready;
    case (rs)
      0: begin
        if (modular_ready) begin
          hs_count++;
          snap_n = numerator;
          snap_d = denominator;
          cnt    = $urandom_range(lat_max, lat_min);
          rs     = 1;
        end
      end
      1: begin
        if (!modular_ready) begin
          rs = 0;
        end else begin
          if (numerator !== snap_n || denominator !== snap_d) stab_err++;
          cnt--;
          if (cnt <= 0) begin
            modular_done = 1'b1;
            mod_result   = (snap_d == 0) ? 32'd0 : snap_n % snap_d;
            rs           = 2;
          end
        end
      end
      2: begin
        if (modular_ready) begin
          if (numerator !== snap_n || denominator !== snap_d) stab_err++;
        end else if (hold_extra > 0) begin
          cnt = hold_extra;
          rs  = 3;
        end else begin
          modular_done = 1'b0;
          rs           = 0;
        end
      end
      default: begin
        cnt--;
        if (cnt <= 0) begin
          modular_done = 1'b0;
          rs           = 0;
        end
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: plain repeated multiplication, no square-and-multiply.
  function automatic longint ref_pow(input longint b, input longint e, input longint n);
    longint acc = 1;
    longint bb  = b % n;
    for (longint i = 0; i < e; i++) acc = (acc * bb) % n;
    return acc;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] b_in, input logic [31:0] e_in,
                        input logic [31:0] n_in);
    longint   exp_r;
    logic     exp_err;
    int       exp_hs;
    int       hs0, p0, s0;
    bit       seen;
    exp_err = (n_in == 0) || (n_in >= 32'h10000);
    if (exp_err || n_in == 1) begin
      exp_r  = 0;
      exp_hs = 0;
    end else begin
      exp_r  = ref_pow(longint'(b_in), longint'(e_in), longint'(n_in));
      exp_hs = (e_in == 0) ? 1 :
               1 + $countones(e_in) + $clog2(longint'(e_in) + 1) - 1;
    end
    hs0  = hs_count;
    p0   = proto_err;
    s0   = stab_err;
    seen = 0;
    @(negedge clk);
    start    = 1'b1;
    base     = b_in;
    exponent = e_in;
    modulus  = n_in;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, " result"}, result, exp_r[31:0]);
    chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, " handshakes"}, hs_count - hs0, exp_hs);
    chk({tag, " early_request"}, proto_err - p0, 32'd0);
    chk({tag, " operand_stable"}, stab_err - s0, 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
    chk({tag, " result"}, result, 32'd0);
    chk({tag, " modular_ready"}, {31'd0, modular_ready}, 32'd0);
    chk({tag, " numerator"}, numerator, 32'd0);
    chk({tag, " denominator"}, denominator, 32'd0);
  endtask

  initial begin
    int  hs0;
    bit  reached;
    reset    = 1'b1;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b0;

    lat_min = 3; lat_max = 3; hold_extra = 0;
    run_op("4^13%497", 32'd4, 32'd13, 32'd497);
    run_op("65^17%3233", 32'd65, 32'd17, 32'd3233);
    run_op("5^0%7", 32'd5, 32'd0, 32'd7);
    run_op("10^3%1", 32'd10, 32'd3, 32'd1);
    run_op("mod0", 32'd10, 32'd3, 32'd0);
    run_op("mod70000", 32'd10, 32'd3, 32'd70000);

    lat_min = 1; lat_max = 20; hold_extra = 5;
    run_op("hold 65^17%3233", 32'd65, 32'd17, 32'd3233);
    for (int k = 0; k < 8; k++) begin
      run_op($sformatf("rand%0d", k), $urandom, $urandom_range(65535, 0),
             $urandom_range(65535, 2));
    end

    // Reset in the middle of the third request, then a fresh operation.
    lat_min = 3; lat_max = 3; hold_extra = 2;
    hs0 = hs_count;
    reached = 0;
    @(negedge clk);
    start    = 1'b1;
    base     = 32'd4;
    exponent = 32'd13;
    modulus  = 32'd497;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ((hs_count - hs0) == 3 && modular_ready) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midreset third_request_reached", {31'd0, reached}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_values("midreset");
    reset = 1'b0;
    run_op("after_reset 4^13%497", 32'd4, 32'd13, 32'd497);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
